// File: rtl/fp_to_int.sv
// Multi-cycle binary32 -> int32/uint32 converter (fcvt.w.s / fcvt.wu.s), one alignment shift per cycle.
// Latency: shift count + 2 cycles from accept to out_valid; results are held in DONE until out_ready.
module fp_to_int #(
    parameter int RSHIFT_CAP = 25
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_x,
    input  logic        is_signed,
    input  logic [2:0]  round_mode,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_z,
    output logic [4:0]  exceptions
);
    localparam int CW = $clog2(((RSHIFT_CAP > 8) ? RSHIFT_CAP : 8) + 1);

    typedef enum logic [1:0] {S_IDLE, S_ALIGN, S_ROUND, S_DONE} state_t;

    state_t         r_state, w_next;
    logic [31:0]    r_mag;
    logic [CW-1:0]  r_cnt;
    logic           r_guard, r_sticky, r_sign, r_signed, r_nan, r_special, r_left;
    logic [2:0]     r_mode;
    logic [31:0]    r_out_z;
    logic [4:0]     r_exc;

    // Operand unpack; exponent arithmetic is done on the biased field (bias 127 + 23 fraction bits = 150).
    logic [7:0]     w_exp;
    logic [23:0]    w_m;
    logic           w_special, w_nan, w_left, w_collapse;
    logic [7:0]     w_lcnt, w_rcnt;
    logic [CW-1:0]  w_cnt_init;

    assign w_exp      = in_x[30:23];
    assign w_m        = {(w_exp != 8'd0), in_x[22:0]};
    assign w_special  = (w_exp >= 8'd159);
    assign w_nan      = (w_exp == 8'hFF) && (in_x[22:0] != 23'd0);
    assign w_left     = (w_exp > 8'd150);
    assign w_lcnt     = w_exp - 8'd150;
    assign w_rcnt     = (w_exp == 8'd0) ? 8'd149 : (8'd150 - w_exp);
    assign w_collapse = !w_special && !w_left && (w_rcnt > 8'(RSHIFT_CAP));

    always_comb begin
        w_cnt_init = '0;
        if (w_special || w_collapse)
            w_cnt_init = '0;
        else if (w_left)
            w_cnt_init = CW'(w_lcnt);
        else
            w_cnt_init = CW'(w_rcnt);
    end

    // Rounding and range check
    logic        w_inc, w_gs, w_oor, w_invalid;
    logic [32:0] w_rnd;
    logic [31:0] w_res;

    assign w_gs = r_guard | r_sticky;

    always_comb begin
        w_inc = 1'b0;
        case (r_mode)
            3'd1:    w_inc = 1'b0;
            3'd2:    w_inc = r_sign & w_gs;
            3'd3:    w_inc = !r_sign & w_gs;
            3'd4:    w_inc = r_guard;
            default: w_inc = r_guard & (r_sticky | r_mag[0]);
        endcase
    end

    assign w_rnd = {1'b0, r_mag} + {32'd0, w_inc};

    always_comb begin
        w_oor = 1'b0;
        if (r_signed)
            w_oor = r_sign ? (w_rnd > 33'h080000000) : (w_rnd > 33'h07FFFFFFF);
        else
            w_oor = r_sign ? (w_rnd != 33'd0) : w_rnd[32];
    end

    assign w_invalid = r_special | w_oor;

    always_comb begin
        w_res = '0;
        if (w_invalid) begin
            if (r_nan || !r_sign)
                w_res = r_signed ? 32'h7FFFFFFF : 32'hFFFFFFFF;
            else
                w_res = r_signed ? 32'h80000000 : 32'h00000000;
        end else begin
            w_res = r_sign ? (32'd0 - w_rnd[31:0]) : w_rnd[31:0];
        end
    end

    // FSM: state register, next-state logic, outputs
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (in_valid) w_next = (w_cnt_init != '0) ? S_ALIGN : S_ROUND;
            S_ALIGN: if (r_cnt == CW'(1)) w_next = S_ROUND;
            S_ROUND: w_next = S_DONE;
            S_DONE:  if (out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready   = (r_state == S_IDLE) && !wb_rst_i;
        out_valid  = (r_state == S_DONE);
        out_z      = r_out_z;
        exceptions = r_exc;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_mag     <= '0;
            r_cnt     <= '0;
            r_guard   <= 1'b0;
            r_sticky  <= 1'b0;
            r_sign    <= 1'b0;
            r_signed  <= 1'b0;
            r_nan     <= 1'b0;
            r_special <= 1'b0;
            r_left    <= 1'b0;
            r_mode    <= '0;
            r_out_z   <= '0;
            r_exc     <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (in_valid) begin
                    r_sign    <= in_x[31];
                    r_signed  <= is_signed;
                    r_mode    <= round_mode;
                    r_nan     <= w_nan;
                    r_special <= w_special;
                    r_left    <= w_left;
                    r_cnt     <= w_cnt_init;
                    r_guard   <= 1'b0;
                    r_sticky  <= w_collapse & (|w_m);
                    r_mag     <= (w_special || w_collapse) ? 32'd0 : {8'd0, w_m};
                end
                S_ALIGN: begin
                    r_cnt <= r_cnt - CW'(1);
                    if (r_left) begin
                        r_mag <= r_mag << 1;
                    end else begin
                        r_mag    <= r_mag >> 1;
                        r_guard  <= r_mag[0];
                        r_sticky <= r_sticky | r_guard;
                    end
                end
                S_ROUND: begin
                    r_out_z <= w_res;
                    r_exc   <= {w_invalid, 3'b000, w_gs & !w_invalid};
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_to_int.sv
// Directed bench for fp_to_int: rounding modes, saturation, specials, latency, backpressure and reset abort.
module tb_fp_to_int;
    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_x;
    logic        is_signed;
    logic [2:0]  round_mode;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_z;
    logic [4:0]  exceptions;

    int n_checks = 0;
    int n_fails  = 0;

    fp_to_int #(.RSHIFT_CAP(25)) dut (
        .wb_clk_i   (wb_clk_i),
        .wb_rst_i   (wb_rst_i),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_x       (in_x),
        .is_signed  (is_signed),
        .round_mode (round_mode),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_z      (out_z),
        .exceptions (exceptions)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one conversion, measure latency, optionally stall the consumer, then drain.
    task automatic convert(input string tag, input logic [31:0] x, input logic sgn, input logic [2:0] mode,
                           input logic [31:0] exp_z, input logic [4:0] exp_exc, input int exp_lat,
                           input int hold);
        int k;
        int w;
        logic [31:0] z0;
        w = 0;
        @(negedge wb_clk_i);
        while (!in_ready && w < 10) begin
            @(negedge wb_clk_i);
            w++;
        end
        check({tag, " in_ready"}, {31'd0, in_ready}, 32'd1);
        in_x       = x;
        is_signed  = sgn;
        round_mode = mode;
        in_valid   = 1'b1;
        @(posedge wb_clk_i);
        #1 in_valid = 1'b0;
        k = 0;
        while (!out_valid && k < 60) begin
            @(posedge wb_clk_i);
            #1 k++;
        end
        check({tag, " lat"}, 32'(k + 1), 32'(exp_lat));
        check({tag, " z"}, out_z, exp_z);
        check({tag, " exc"}, {27'd0, exceptions}, {27'd0, exp_exc});
        z0 = out_z;
        for (int i = 0; i < hold; i++) begin
            @(posedge wb_clk_i);
            #1;
            check({tag, " hold valid"}, {31'd0, out_valid}, 32'd1);
            check({tag, " hold z"}, out_z, z0);
            check({tag, " hold in_ready"}, {31'd0, in_ready}, 32'd0);
        end
        @(negedge wb_clk_i);
        out_ready = 1'b1;
        @(posedge wb_clk_i);
        #1 out_ready = 1'b0;
        check({tag, " drained"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        int k;
        wb_rst_i   = 1'b1;
        in_valid   = 1'b0;
        in_x       = '0;
        is_signed  = 1'b0;
        round_mode = '0;
        out_ready  = 1'b0;
        repeat (3) @(posedge wb_clk_i);
        #1;
        check("rst in_ready",  {31'd0, in_ready},  32'd0);
        check("rst out_valid", {31'd0, out_valid}, 32'd0);
        check("rst out_z",     out_z,              32'd0);
        check("rst exc",       {27'd0, exceptions}, 32'd0);
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        #1 check("post-rst in_ready", {31'd0, in_ready}, 32'd1);

        convert("1.5 RNE",   32'h3FC00000, 1'b1, 3'd0, 32'd2, 5'h01, 25, 0);
        convert("1.5 RTZ",   32'h3FC00000, 1'b1, 3'd1, 32'd1, 5'h01, 25, 0);
        convert("2.5 RNE",   32'h40200000, 1'b1, 3'd0, 32'd2, 5'h01, 24, 0);
        convert("2.5 RMM",   32'h40200000, 1'b1, 3'd4, 32'd3, 5'h01, 24, 0);
        convert("2.5 RUP",   32'h40200000, 1'b1, 3'd3, 32'd3, 5'h01, 24, 0);
        convert("2.5 RDN",   32'h40200000, 1'b1, 3'd2, 32'd2, 5'h01, 24, 0);
        convert("2.5 mode7", 32'h40200000, 1'b1, 3'd7, 32'd2, 5'h01, 24, 0);
        convert("-0.5 U",    32'hBF000000, 1'b0, 3'd1, 32'd0, 5'h01, 26, 0);
        convert("-1.0 U",    32'hBF800000, 1'b0, 3'd1, 32'd0, 5'h10, 25, 0);
        convert("-2^31 S",   32'hCF000000, 1'b1, 3'd0, 32'h80000000, 5'h00, 10, 5);
        convert("2^31 S",    32'h4F000000, 1'b1, 3'd0, 32'h7FFFFFFF, 5'h10, 10, 0);
        convert("2^31 U",    32'h4F000000, 1'b0, 3'd0, 32'h80000000, 5'h00, 10, 0);
        convert("NaN S",     32'h7FC00000, 1'b1, 3'd0, 32'h7FFFFFFF, 5'h10, 2, 0);
        convert("-inf U",    32'hFF800000, 1'b0, 3'd0, 32'h00000000, 5'h10, 2, 0);
        convert("e23",       32'h4B000001, 1'b1, 3'd0, 32'h00800001, 5'h00, 2, 0);
        convert("0.25 RUP",  32'h3E800000, 1'b1, 3'd3, 32'd1, 5'h01, 27, 0);
        convert("0.125 RUP", 32'h3E000000, 1'b1, 3'd3, 32'd1, 5'h01, 2, 0);
        convert("0.125 RNE", 32'h3E000000, 1'b1, 3'd0, 32'd0, 5'h01, 2, 0);
        convert("-sub RDN",  32'h80000001, 1'b1, 3'd2, 32'hFFFFFFFF, 5'h01, 2, 0);
        convert("+0 RUP",    32'h00000000, 1'b1, 3'd3, 32'd0, 5'h00, 2, 0);

        // Abort a conversion mid-alignment with reset
        @(negedge wb_clk_i);
        in_x       = 32'h3FC00000;
        is_signed  = 1'b1;
        round_mode = 3'd0;
        in_valid   = 1'b1;
        @(posedge wb_clk_i);
        #1 in_valid = 1'b0;
        repeat (5) @(posedge wb_clk_i);
        @(negedge wb_clk_i);
        wb_rst_i = 1'b1;
        @(posedge wb_clk_i);
        #1;
        check("abort out_valid", {31'd0, out_valid}, 32'd0);
        check("abort out_z",     out_z,              32'd0);
        check("abort in_ready",  {31'd0, in_ready},  32'd0);
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        #1 check("abort idle", {31'd0, in_ready}, 32'd1);
        k = 0;
        repeat (30) begin
            @(posedge wb_clk_i);
            #1 if (out_valid) k++;
        end
        check("abort no result", 32'(k), 32'd0);

        convert("3.0 RNE", 32'h40400000, 1'b1, 3'd0, 32'd3, 5'h00, 24, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
